// File: rtl/onehot_req_dispatch.sv
// onehot_req_dispatch
//   Takes one encoded event index per valid/ready transfer and raises exactly
//   one of N request lines, running a four-phase req/ack handshake on that line.
//   A request that sees no ack within TIMEOUT cycles is aborted with an
//   err_tmo pulse. An index >= N is dropped with an err_idx pulse. done_cnt
//   counts handshakes that saw ack high, and wraps.
//
// Ports
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset
//   in_valid  in   1      encoded event present
//   in_ready  out  1      high only in IDLE (decoded from state alone)
//   in_idx    in   IDX_W  target line index, sampled on accept
//   out_req   out  N      one-hot or zero request lines, registered
//   out_ack   in   N      per-line acknowledge from consumers
//   busy      out  1      handshake in progress (state != IDLE)
//   err_idx   out  1      1-cycle pulse: accepted index >= N, event dropped
//   err_tmo   out  1      1-cycle pulse: ack timeout, request aborted
//   done_cnt  out  CNT_W  completed handshakes, wraps
//
// state | meaning
// IDLE  | ready for a new event, out_req = 0
// REQ   | out_req[idx] high, waiting for out_ack[idx] or timeout
// DRAIN | out_req = 0, waiting for out_ack[idx] to return low
module onehot_req_dispatch #(
    parameter int N       = 8,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    output logic [N-1:0]     out_req,
    input  logic [N-1:0]     out_ack,
    output logic             busy,
    output logic             err_idx,
    output logic             err_tmo,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    // One extra bit so N = 2**IDX_W is still representable as a limit.
    localparam logic [IDX_W:0]   N_LIM    = (IDX_W + 1)'(N);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [TMO_W-1:0]   tmo, tmo_nxt;
    logic [N-1:0]       req_nxt;
    logic               err_idx_nxt, err_tmo_nxt;
    logic [CNT_W-1:0]   done_nxt;

    logic               idx_ok;
    logic [N-1:0]       in_dec;
    logic               ack_sel;

    // Decode and ack select are written as compare loops so that IDX_W wider
    // than clog2(N) never indexes past the end of the N-bit vectors.
    always_comb begin
        idx_ok  = ({1'b0, in_idx} < N_LIM);
        in_dec  = '0;
        ack_sel = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_idx == IDX_W'(i)) in_dec[i] = 1'b1;
            if (idx == IDX_W'(i))    ack_sel   = out_ack[i];
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        tmo_nxt     = tmo;
        req_nxt     = '0;
        err_idx_nxt = 1'b0;
        err_tmo_nxt = 1'b0;
        done_nxt    = done_cnt;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (idx_ok) begin
                        state_nxt = REQ;
                        idx_nxt   = in_idx;
                        tmo_nxt   = '0;
                        req_nxt   = in_dec;
                    end else begin
                        err_idx_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                // Ack takes priority over a timeout landing on the same edge.
                if (ack_sel) begin
                    state_nxt = DRAIN;
                    done_nxt  = done_cnt + 1'b1;
                end else if (tmo == TMO_LAST) begin
                    state_nxt   = DRAIN;
                    err_tmo_nxt = 1'b1;
                end else begin
                    tmo_nxt = tmo + 1'b1;
                    req_nxt = out_req;
                end
            end
            DRAIN: begin
                if (!ack_sel) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            tmo      <= '0;
            out_req  <= '0;
            err_idx  <= 1'b0;
            err_tmo  <= 1'b0;
            done_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            tmo      <= tmo_nxt;
            out_req  <= req_nxt;
            err_idx  <= err_idx_nxt;
            err_tmo  <= err_tmo_nxt;
            done_cnt <= done_nxt;
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_onehot_req_dispatch.sv
// Bench for onehot_req_dispatch, built with N=6 so that indices 6 and 7 are
// illegal, TIMEOUT=15, and an 8-bit done_cnt so the wrap is reachable quickly.
// Inputs are driven and outputs sampled on the falling edge.
module tb_onehot_req_dispatch;

    localparam int TN   = 6;
    localparam int TIW  = 3;
    localparam int TTMO = 15;
    localparam int TCW  = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [TIW-1:0]  in_idx;
    logic [TN-1:0]   out_req;
    logic [TN-1:0]   out_ack;
    logic            busy;
    logic            err_idx;
    logic            err_tmo;
    logic [TCW-1:0]  done_cnt;

    int              total = 0;
    int              bad   = 0;
    logic [TCW-1:0]  exp_cnt = '0;

    onehot_req_dispatch #(
        .N       (TN),
        .IDX_W   (TIW),
        .TIMEOUT (TTMO),
        .CNT_W   (TCW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_idx   (in_idx),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .busy     (busy),
        .err_idx  (err_idx),
        .err_tmo  (err_tmo),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int             req_len;
        logic [TN-1:0]  req_after;
        logic           ready_acc;
        logic           busy_1;
        logic           err_idx_1;
        logic           err_idx_2;
        logic           err_tmo_1;
        logic           err_tmo_2;
        logic           busy_drop;
        logic           idle_end;
        int             drain_bad;
        logic [TCW-1:0] cnt_end;
    } obs_t;

    // Drives one event and records what the DUT did. The ack for a legal
    // index rises d cycles after req is first seen and stays high for h extra
    // DRAIN cycles. With noise set, the other ack lines toggle randomly.
    task automatic do_event(input int idx, input int d, input int h,
                            input bit noise, output obs_t o);
        logic [TN-1:0] oh;
        logic [TN-1:0] rnd;
        int            n;
        o.req_len   = 0;
        o.req_after = '0;
        o.busy_1    = 1'b0;
        o.err_idx_2 = 1'b0;
        o.err_tmo_1 = 1'b0;
        o.err_tmo_2 = 1'b0;
        o.busy_drop = 1'b0;
        o.drain_bad = 0;
        oh = TN'(1) << idx;
        @(negedge clk);
        o.ready_acc = in_ready;
        in_valid = 1'b1;
        in_idx   = TIW'(idx);
        @(negedge clk);
        in_valid = 1'b0;
        o.err_idx_1 = err_idx;
        o.busy_1    = busy;
        if (idx >= TN) begin
            o.req_after = out_req;
            @(negedge clk);
            o.err_idx_2 = err_idx;
        end else begin
            n = 1;
            while (out_req === oh && n < 40) begin
                if (n - 1 == d) out_ack = out_ack | oh;
                if (noise) begin
                    rnd     = TN'($urandom);
                    out_ack = (out_ack & oh) | (rnd & ~oh);
                end
                @(negedge clk);
                n++;
            end
            o.req_len   = n - 1;
            o.req_after = out_req;
            o.err_tmo_1 = err_tmo;
            o.busy_drop = busy;
            out_ack = out_ack & oh;
            if ((out_ack & oh) != '0) begin
                repeat (h) begin
                    @(negedge clk);
                    if (busy !== 1'b1 || out_req !== '0 || err_tmo !== 1'b0)
                        o.drain_bad++;
                end
                out_ack = '0;
            end
            @(negedge clk);
            o.err_tmo_2 = err_tmo;
        end
        o.idle_end = (in_ready === 1'b1) && (busy === 1'b0);
        o.cnt_end  = done_cnt;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_idx   = '0;
        out_ack  = '0;
        repeat (2) @(negedge clk);
        total++;
        if (out_req !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: req=%b busy=%b ready=%b want req=0 busy=0 ready=1",
                     out_req, busy, in_ready);
        end
        total++;
        if (err_idx !== 1'b0 || err_tmo !== 1'b0 || done_cnt !== '0) begin
            bad++;
            $display("FAIL reset_flags: err_idx=%b err_tmo=%b cnt=%0d want 0 0 0",
                     err_idx, err_tmo, done_cnt);
        end
        reset   = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic test_basic();
        obs_t o;
        do_event(5, 2, 2, 1'b0, o);
        exp_cnt++;
        total++;
        if (o.ready_acc !== 1'b1) begin
            bad++; $display("FAIL basic_ready: got %b want 1", o.ready_acc);
        end
        total++;
        if (o.req_len != 3) begin
            bad++; $display("FAIL basic_req_len: got %0d want 3", o.req_len);
        end
        total++;
        if (o.req_after !== '0 || o.busy_drop !== 1'b1 || o.err_tmo_1 !== 1'b0) begin
            bad++;
            $display("FAIL basic_drain: req=%b busy=%b err_tmo=%b want 0 1 0",
                     o.req_after, o.busy_drop, o.err_tmo_1);
        end
        total++;
        if (o.drain_bad != 0 || o.idle_end !== 1'b1) begin
            bad++;
            $display("FAIL basic_return: drain_bad=%0d idle=%b want 0 1", o.drain_bad, o.idle_end);
        end
        total++;
        if (o.cnt_end !== exp_cnt) begin
            bad++; $display("FAIL basic_cnt: got %0d want %0d", o.cnt_end, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        obs_t o;
        for (int k = 6; k <= 7; k++) begin
            do_event(k, 0, 0, 1'b0, o);
            total++;
            if (o.err_idx_1 !== 1'b1 || o.err_idx_2 !== 1'b0) begin
                bad++;
                $display("FAIL illegal_pulse idx=%0d: got %b,%b want 1,0", k, o.err_idx_1, o.err_idx_2);
            end
            total++;
            if (o.req_after !== '0 || o.busy_1 !== 1'b0 || o.idle_end !== 1'b1) begin
                bad++;
                $display("FAIL illegal_idle idx=%0d: req=%b busy=%b idle=%b want 0 0 1",
                         k, o.req_after, o.busy_1, o.idle_end);
            end
            total++;
            if (o.cnt_end !== exp_cnt) begin
                bad++; $display("FAIL illegal_cnt idx=%0d: got %0d want %0d", k, o.cnt_end, exp_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_event(2, 1000, 0, 1'b0, o);
        total++;
        if (o.req_len != TTMO) begin
            bad++; $display("FAIL tmo_req_len: got %0d want %0d", o.req_len, TTMO);
        end
        total++;
        if (o.err_tmo_1 !== 1'b1 || o.err_tmo_2 !== 1'b0) begin
            bad++; $display("FAIL tmo_pulse: got %b,%b want 1,0", o.err_tmo_1, o.err_tmo_2);
        end
        total++;
        if (o.busy_drop !== 1'b1 || o.idle_end !== 1'b1 || o.cnt_end !== exp_cnt) begin
            bad++;
            $display("FAIL tmo_return: busy=%b idle=%b cnt=%0d want 1 1 %0d",
                     o.busy_drop, o.idle_end, o.cnt_end, exp_cnt);
        end
    endtask

    task automatic test_ack_prehigh();
        obs_t o;
        @(negedge clk);
        out_ack = 6'b011000;
        do_event(3, 0, 3, 1'b1, o);
        exp_cnt++;
        total++;
        if (o.req_len != 1) begin
            bad++; $display("FAIL prehigh_req_len: got %0d want 1", o.req_len);
        end
        total++;
        if (o.err_tmo_1 !== 1'b0 || o.busy_drop !== 1'b1 || o.drain_bad != 0) begin
            bad++;
            $display("FAIL prehigh_drain: err_tmo=%b busy=%b drain_bad=%0d want 0 1 0",
                     o.err_tmo_1, o.busy_drop, o.drain_bad);
        end
        total++;
        if (o.cnt_end !== exp_cnt || o.idle_end !== 1'b1) begin
            bad++;
            $display("FAIL prehigh_cnt: cnt=%0d idle=%b want %0d 1", o.cnt_end, o.idle_end, exp_cnt);
        end
    endtask

    // in_valid held high and every ack echoing its req: one accept every
    // three cycles, so 30 edges starting in IDLE give exactly 10 handshakes.
    task automatic test_back_to_back();
        int req_cycles = 0;
        int multi      = 0;
        logic [TCW-1:0] start;
        @(negedge clk);
        start    = done_cnt;
        in_valid = 1'b1;
        in_idx   = 3'd4;
        repeat (30) begin
            @(negedge clk);
            out_ack = out_req;
            if (out_req != '0) req_cycles++;
            if ($countones(out_req) > 1) multi++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ack = '0;
        @(negedge clk);
        exp_cnt = exp_cnt + TCW'(10);
        total++;
        if (req_cycles != 10 || multi != 0) begin
            bad++;
            $display("FAIL b2b_req: req_cycles=%0d multi=%0d want 10 0", req_cycles, multi);
        end
        total++;
        if (done_cnt !== start + TCW'(10)) begin
            bad++; $display("FAIL b2b_cnt: got %0d want %0d", done_cnt, start + TCW'(10));
        end
    endtask

    task automatic test_random();
        obs_t o;
        int idx, d, h, exp_len;
        bit exp_to;
        for (int e = 0; e < 60; e++) begin
            idx = $urandom_range(0, 7);
            d   = $urandom_range(0, 20);
            h   = $urandom_range(0, 3);
            do_event(idx, d, h, 1'b1, o);
            total++;
            if (idx >= TN) begin
                if (o.err_idx_1 !== 1'b1 || o.err_idx_2 !== 1'b0 || o.req_after !== '0
                    || o.idle_end !== 1'b1 || o.cnt_end !== exp_cnt) begin
                    bad++;
                    $display("FAIL rand_illegal e=%0d idx=%0d: err=%b,%b req=%b idle=%b cnt=%0d want 1,0 0 1 %0d",
                             e, idx, o.err_idx_1, o.err_idx_2, o.req_after, o.idle_end,
                             o.cnt_end, exp_cnt);
                end
            end else begin
                exp_to  = (d + 1 > TTMO);
                exp_len = exp_to ? TTMO : d + 1;
                if (!exp_to) exp_cnt++;
                if (o.req_len != exp_len || o.err_tmo_1 !== exp_to || o.err_tmo_2 !== 1'b0
                    || o.err_idx_1 !== 1'b0 || o.req_after !== '0 || o.busy_drop !== 1'b1
                    || o.drain_bad != 0 || o.idle_end !== 1'b1 || o.cnt_end !== exp_cnt) begin
                    bad++;
                    $display("FAIL rand_event e=%0d idx=%0d d=%0d: len=%0d tmo=%b,%b err_idx=%b req=%b busy=%b drain_bad=%0d idle=%b cnt=%0d want len=%0d tmo=%b,0 cnt=%0d",
                             e, idx, d, o.req_len, o.err_tmo_1, o.err_tmo_2, o.err_idx_1,
                             o.req_after, o.busy_drop, o.drain_bad, o.idle_end, o.cnt_end,
                             exp_len, exp_to, exp_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        in_idx   = 3'd1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_req !== 6'b000010) begin
            bad++; $display("FAIL rst_mid_req: got %b want 000010", out_req);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = '0;
        total++;
        if (out_req !== '0 || busy !== 1'b0 || in_ready !== 1'b1
            || done_cnt !== '0 || err_tmo !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_state: req=%b busy=%b ready=%b cnt=%0d err_tmo=%b want 0 0 1 0 0",
                     out_req, busy, in_ready, done_cnt, err_tmo);
        end
    endtask

    task automatic test_wrap();
        obs_t o;
        for (int e = 0; e < 255; e++) begin
            do_event(e % TN, 0, 0, 1'b0, o);
            exp_cnt++;
        end
        total++;
        if (o.cnt_end !== 8'hFF || exp_cnt !== 8'hFF) begin
            bad++; $display("FAIL wrap_top: got %0d want 255", o.cnt_end);
        end
        do_event(0, 0, 0, 1'b0, o);
        exp_cnt++;
        total++;
        if (o.cnt_end !== 8'h00) begin
            bad++; $display("FAIL wrap_zero: got %0d want 0", o.cnt_end);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_illegal();
        test_timeout();
        test_ack_prehigh();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
